// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: unpack/compare, align/add, normalise/round.
// Denormals are flushed to zero on input and output; rounding is nearest-even.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_res,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int F    = MAN_W + 4;
    localparam int LZ_W = $clog2(F + 1);
    localparam int E_W  = EXP_W + 2;
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [E_W-1:0] EXP_INF  = {2'b00, EXP_ONES};
    localparam logic signed [E_W-1:0] EXP_ONE  = {{(E_W-1){1'b0}}, 1'b1};
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;

    function automatic logic [LZ_W-1:0] lzc(input logic [F-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(F);
        for (int i = 0; i < F; i++)
            if (v[i]) n = LZ_W'(F - 1 - i);
        return n;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // stage 1: unpack, classify, order by magnitude
    logic             sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap, spec_c;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb;
    logic [W-2:0]     key_a, key_b;
    logic [W-1:0]     spec_res_c;
    logic [3:0]       spec_flags_c;

    always_comb begin
        sa     = in_a[W-1];
        sb     = in_b[W-1] ^ in_sub;
        ea     = in_a[W-2:MAN_W];
        eb     = in_b[W-2:MAN_W];
        fa     = in_a[MAN_W-1:0];
        fb     = in_b[MAN_W-1:0];
        ma     = (ea == '0) ? '0 : {1'b1, fa};
        mb     = (eb == '0) ? '0 : {1'b1, fb};
        key_a  = (ea == '0) ? '0 : in_a[W-2:0];
        key_b  = (eb == '0) ? '0 : in_b[W-2:0];
        swap   = key_b > key_a;
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
        spec_c       = a_nan || b_nan || a_inf || b_inf;
        spec_res_c   = QNAN;
        spec_flags_c = 4'b0000;
        if (a_nan || b_nan)
            spec_flags_c = {a_snan || b_snan, 3'b000};
        else if (a_inf && b_inf && (sa != sb))
            spec_flags_c = 4'b1000;
        else if (a_inf)
            spec_res_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else if (b_inf)
            spec_res_c = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    logic             s1_valid, s1_spec, s1_sx, s1_sy;
    logic [TAG_W-1:0] s1_tag;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_ex, s1_ey;
    logic [MAN_W:0]   s1_mx, s1_my;

    // stage 2: align the smaller operand and add/subtract
    logic [EXP_W-1:0] d;
    logic [F-1:0]     ext, sh, aligned;
    logic             lost;
    logic [F:0]       sum_c;

    always_comb begin
        d    = s1_ex - s1_ey;
        ext  = {s1_my, 3'b000};
        sh   = '0;
        lost = 1'b0;
        if (d >= EXP_W'(F - 1)) begin
            aligned = {{(F-1){1'b0}}, |s1_my};
        end else begin
            sh      = ext >> d;
            lost    = |(ext & ~({F{1'b1}} << d));
            aligned = {sh[F-1:1], sh[0] | lost};
        end
        if (s1_sx ^ s1_sy)
            sum_c = {1'b0, s1_mx, 3'b000} - {1'b0, aligned};
        else
            sum_c = {1'b0, s1_mx, 3'b000} + {1'b0, aligned};
    end

    logic             s2_valid, s2_spec, s2_sign, s2_zero_sign;
    logic [TAG_W-1:0] s2_tag;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [EXP_W-1:0] s2_ex;
    logic [F:0]       s2_sum;

    // stage 3: normalise, round, range-check
    logic [LZ_W-1:0]        lz;
    logic [F-1:0]           norm;
    logic signed [E_W-1:0]  exp_base, exp_n;
    logic [MAN_W+1:0]       mant_r;
    logic                   g, r, st, inc;
    logic [W-1:0]           res_c;
    logic [3:0]             flags_c;

    always_comb begin
        lz       = lzc(s2_sum[F-1:0]);
        exp_base = signed'({2'b00, s2_ex});
        if (s2_sum[F]) begin
            norm  = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
            exp_n = exp_base + EXP_ONE;
        end else begin
            norm  = s2_sum[F-1:0] << lz;
            exp_n = exp_base - signed'({{(E_W-LZ_W){1'b0}}, lz});
        end
        g      = norm[2];
        r      = norm[1];
        st     = norm[0];
        inc    = g & (r | st | norm[3]);
        mant_r = {1'b0, norm[F-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        // a rounding carry leaves the stored fraction at zero, only the exponent moves
        if (mant_r[MAN_W+1])
            exp_n = exp_n + EXP_ONE;
        if (s2_spec) begin
            res_c   = s2_spec_res;
            flags_c = s2_spec_flags;
        end else if (s2_sum == '0) begin
            res_c   = {s2_zero_sign, {(W-1){1'b0}}};
            flags_c = 4'b0000;
        end else if (exp_n >= EXP_INF) begin
            res_c   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_c = 4'b0101;
        end else if (exp_n <= EXP_ZERO) begin
            res_c   = {s2_sign, {(W-1){1'b0}}};
            flags_c = 4'b0011;
        end else begin
            res_c   = {s2_sign, exp_n[EXP_W-1:0], mant_r[MAN_W-1:0]};
            flags_c = {3'b000, g | r | st};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res   <= res_c;
                out_tag   <= s2_tag;
                out_flags <= flags_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag        <= in_tag;
            s1_spec       <= spec_c;
            s1_spec_res   <= spec_res_c;
            s1_spec_flags <= spec_flags_c;
            s1_sx         <= swap ? sb : sa;
            s1_sy         <= swap ? sa : sb;
            s1_ex         <= swap ? eb : ea;
            s1_ey         <= swap ? ea : eb;
            s1_mx         <= swap ? mb : ma;
            s1_my         <= swap ? ma : mb;
            s2_tag        <= s1_tag;
            s2_spec       <= s1_spec;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sx;
            s2_zero_sign  <= s1_sx & s1_sy;
            s2_ex         <= s1_ex;
            s2_sum        <= sum_c;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary32): directed corner cases, stall/reset scenarios and a
// random stream checked against an exact big-integer reference with round-to-nearest-even.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [4:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_recv   = 0;
    int          stall_seen = 0;
    logic        hold = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    logic [3:0]  prev_flags;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Exact value of each operand as an integer multiple of 2^-149, summed exactly, then rounded.
    function automatic logic [35:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic               sa, sb, a_nan, b_nan, a_inf, b_inf, s, up;
        logic [7:0]         ea, eb;
        logic [22:0]        fa, fb;
        logic signed [299:0] va, vb, sum;
        logic [299:0]       mag, q, rem, half, one;
        int                 p, e, sh;
        sa = a[31]; sb = b[31] ^ sub;
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        a_nan = (ea == 8'hFF) && (fa != 0);
        b_nan = (eb == 8'hFF) && (fb != 0);
        a_inf = (ea == 8'hFF) && (fa == 0);
        b_inf = (eb == 8'hFF) && (fb == 0);
        if (a_nan || b_nan)
            return {(a_nan && !fa[22]) || (b_nan && !fb[22]), 3'b000, 32'h7FC00000};
        if (a_inf && b_inf && (sa != sb)) return {4'b1000, 32'h7FC00000};
        if (a_inf) return {4'b0000, sa, 8'hFF, 23'd0};
        if (b_inf) return {4'b0000, sb, 8'hFF, 23'd0};
        va = 0; vb = 0;
        if (ea != 0) begin
            mag = 0; mag[23:0] = {1'b1, fa};
            va = mag << (ea - 1);
            if (sa) va = -va;
        end
        if (eb != 0) begin
            mag = 0; mag[23:0] = {1'b1, fb};
            vb = mag << (eb - 1);
            if (sb) vb = -vb;
        end
        sum = va + vb;
        if (sum == 0) return {4'b0000, sa & sb, 31'd0};
        s   = sum < 0;
        mag = s ? -sum : sum;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {4'b0011, s, 31'd0};
        e   = p - 22;
        sh  = p - 23;
        one = 1;
        q   = mag >> sh;
        rem = mag & ((one << sh) - one);
        up  = 1'b0;
        if (sh > 0) begin
            half = one << (sh - 1);
            up = (rem > half) || ((rem == half) && q[0]);
        end
        q = q + up;
        if (q[24]) begin q = q >> 1; e++; end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        return {3'b000, rem != 0, s, e[7:0], q[22:0]};
    endfunction

    // scoreboard and hold-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_t  e;
        logic [35:0] m;
        if (!rst_n) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res", out_res, e.res);
                    chk("flags", out_flags, e.flags);
                    chk("tag", out_tag, e.tag);
                    n_recv++;
                end
            end
            if (out_valid && !out_ready) begin
                if (hold) begin
                    chk("hold_res", out_res, prev_res);
                    chk("hold_tag", out_tag, prev_tag);
                    chk("hold_flags", out_flags, prev_flags);
                end
                hold = 1'b1;
                prev_res = out_res; prev_tag = out_tag; prev_flags = out_flags;
            end else hold = 1'b0;
            if (in_valid && in_ready) begin
                m = fp_ref(in_a, in_b, in_sub);
                e.res = m[31:0]; e.flags = m[35:32]; e.tag = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    // called right after posedge+1; returns at posedge+1 of the transfer edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [4:0] tag);
        logic ok;
        int   n;
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        n = 0;
        forever begin
            #1 ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 200) begin chk("send_timeout", n, 0); break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [31:0] want_res, input logic [3:0] want_flags, input string name);
        int lat;
        out_ready = 1'b1;
        send(a, b, sub, 5'd9);
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_res"}, out_res, want_res);
        chk({name, "_flags"}, out_flags, want_flags);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_normal(input int base_exp);
        int e;
        e = (base_exp < 0) ? int'($urandom_range(1, 254)) : base_exp + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), e[7:0], 23'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        int          r0, nv, done;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        run_one(32'h3E800000, 32'h42C80000, 1'b0, 32'h42C88000, 4'b0000, "quarter_plus_100");
        run_one(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one");
        run_one(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even");
        run_one(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_minus_inf");
        run_one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
        run_one(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "neg_zero_sum");
        run_one(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, "inf_plus_finite");
        run_one(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "snan");
        run_one(32'h00800001, 32'h80800000, 1'b0, 32'h00000000, 4'b0011, "underflow_ftz");

        // back-to-back stream with the consumer stalling in cycles 4-7
        r0 = n_recv; done = 0;
        fork
            for (int i = 0; i < 8; i++)
                send(32'h3F800000 + 32'(i << 20), 32'h40000000, i[0], 5'(i));
            for (int c = 0; c < 14; c++) begin
                out_ready = !(c >= 4 && c <= 7);
                #1;
                if (out_valid && !out_ready) begin
                    stall_seen++;
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        chk("stream_count", n_recv - r0, 8);
        chk("stream_stalled", stall_seen > 0, 1);

        // reset with two operations in flight
        send(32'h40400000, 32'h3F800000, 1'b0, 5'd20);
        send(32'h40800000, 32'h3F800000, 1'b1, 5'd21);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        nv = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) nv++; end
        chk("midrst_no_stale", nv, 0);

        // random normals with a randomly stalling consumer
        r0 = n_recv;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    a = rand_normal(-1);
                    b = ($urandom_range(0, 1) == 1) ? rand_normal(int'(a[30:23])) : rand_normal(-1);
                    if ($urandom_range(0, 15) == 0) b = {~a[31], a[30:0]};
                    send(a, b, 1'($urandom_range(0, 1)), 5'($urandom));
                end
                done = 1;
            end
            while (done == 0) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        chk("random_drain", exp_q.size(), 0);
        chk("random_count", n_recv - r0, 10000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
